cordic_sincos: RTL and testbench
================================

Name: cordic_sincos

Overview:
- Iterative CORDIC in rotation mode; the inverse of the existing vectoring-mode arctan/magnitude block.
- Takes an angle in degrees, scaled ×2^16 (same angle scaling and same 16-entry ROT table as the vectoring block).
- Returns cos and sin scaled ×2^16.
- One micro-rotation per clock on a single shared datapath. Valid/ready handshake on both sides so it can sit between a phase accumulator and downstream DSP or test logic.

Parameters:
- ITER, 16, number of micro-rotations. Fixed at 16 to match the ROT table.
- KN, 39797, CORDIC gain compensation 0.60725×2^16. Loaded as the initial x.
- DEG90, 5898240, 90°×2^16. Quadrant-fold threshold.
- DEG180, 11796480, 180°×2^16. Range limit and fold offset.

Ports:
- clk, in, 1, system clock (50 MHz).
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, angle_in is valid.
- in_ready, out, 1, block can accept an angle. High only in IDLE.
- angle_in, in, 32, signed angle, degrees×2^16.
- out_valid, out, 1, results valid.
- out_ready, in, 1, consumer accepts results.
- cos_out, out, 32, signed cos×2^16.
- sin_out, out, 32, signed sin×2^16.
- range_err, out, 1, accepted angle was outside ±180°. Qualified by out_valid.
- busy, out, 1, state is ROTATE or DONE.

Behaviour:

Reset:
- rst_n low sets state=IDLE.
- x, y, z, iter, neg, cos_out, sin_out, range_err, out_valid all go to 0.
- in_ready goes to 1 one cycle after release. In-flight work is discarded, with no partial output.

Angle table (degrees×2^16): ROT0..ROT15 = 2949120, 1740970, 919876, 466944, 234376, 117303, 58668, 29334, 14667, 7333, 3670, 1835, 918, 459, 229, 118.

FSM states: IDLE, ROTATE, DONE.

IDLE:
- in_ready=1.
- On an edge with in_valid=1, capture the angle and go to ROTATE:
  - x=KN, y=0, iter=0.
  - angle > DEG90: z = angle − DEG180, neg=1.
  - angle < −DEG90: z = angle + DEG180, neg=1.
  - Otherwise: z = angle, neg=0.
  - Exactly ±DEG90 is not folded.
  - |angle| > DEG180: set err flag, still run.

ROTATE, each edge, with i=iter:
- If z ≥ 0 (z[31]=0):
  - x ← x − (y>>>i)
  - y ← y + (x>>>i)
  - z ← z − ROTi
- Else:
  - x ← x + (y>>>i)
  - y ← y − (x>>>i)
  - z ← z + ROTi
- All shifts are arithmetic. All arithmetic is 32-bit two's complement with no saturation. iter increments each edge.
- On the edge with iter=15, go to DONE, load the outputs and set out_valid=1:
  - cos_out = neg ? −x_next : x_next
  - sin_out = neg ? −y_next : y_next
  - range_err = err flag
- When range_err=1, cos_out and sin_out are forced to 0.

DONE:
- out_valid=1. cos_out, sin_out and range_err are held stable until an edge with out_ready=1.
- That edge sets out_valid=0 and returns to IDLE.
- in_ready rises the following cycle, so a new angle cannot be accepted in the same edge that completes the output handshake.

Latency:
- Angle accepted at edge N; out_valid is high after edge N+16.
- Minimum throughput is 18 cycles per result with out_ready tied high.

Handshake and boundary rules:
- in_valid is ignored outside IDLE; the angle must be held by the producer.
- cos_out and sin_out retain their last values while out_valid=0.
- Accuracy for in-range angles is |error| ≤ 8 LSB versus round(2^16·cos/sin).

Test Plan:
1. Reset mid-ROTATE: assert rst_n low at iter=7 → all outputs 0, IDLE, no out_valid pulse after release.
2. angle_in=0 → cos_out=65536±8, sin_out=0±8, out_valid exactly 16 edges after acceptance, range_err=0.
3. angle_in=1966080 (30°) → cos=56756±8, sin=32768±8. angle_in=−1966080 → sin=−32768±8.
4. Fold: angle_in=8847360 (135°) → cos=−46341±8, sin=46341±8. angle_in=−DEG90 (−5898240) → cos=0±8, sin=−65536±8.
5. Backpressure: hold out_ready=0 for 20 cycles → outputs stable, in_ready=0, and in_valid pulses during that time are not captured. out_ready=1 → out_valid falls, in_ready rises one cycle later.
6. angle_in=12000000 → range_err=1, cos_out=sin_out=0. Back-to-back stream with out_ready=1 gives one result per 18 cycles.

Source files
------------

// File: rtl/cordic_sincos_if.sv
// Handshake bundle for cordic_sincos: angle in, cos/sin out.
// Zero latency (wires only).
// Both directions use valid/ready: producer side in_valid/in_ready, consumer side out_valid/out_ready.
//
// Ports: in_valid/in_ready/angle_in (angle request, degrees x 2^16),
//        out_valid/out_ready/cos_out/sin_out/range_err (result), busy (status).
interface cordic_sincos_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] angle_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] cos_out;
  logic signed [31:0] sin_out;
  logic               range_err;
  logic               busy;

  // Producer/consumer side (testbench, phase accumulator, downstream DSP).
  modport master (
    output in_valid, angle_in, out_ready,
    input  in_ready, out_valid, cos_out, sin_out, range_err, busy
  );

  // Block side.
  modport slave (
    input  in_valid, angle_in, out_ready,
    output in_ready, out_valid, cos_out, sin_out, range_err, busy
  );
endinterface

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: angle (deg x 2^16) -> cos/sin (x 2^16), one micro-rotation per clock.
// Latency: angle accepted at edge N, out_valid high after edge N+16; 18 cycles per result with out_ready high.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so no new angle while a result waits.
//
// Ports: clk, rst_n (async active-low), io (cordic_sincos_if.slave):
//   in_valid/in_ready/angle_in, out_valid/out_ready/cos_out/sin_out/range_err, busy.
module cordic_sincos #(
  parameter int                 ITER   = 16,
  parameter logic signed [31:0] KN     = 32'sd39797,
  parameter logic signed [31:0] DEG90  = 32'sd5898240,
  parameter logic signed [31:0] DEG180 = 32'sd11796480
) (
  input  logic             clk,
  input  logic             rst_n,
  cordic_sincos_if.slave   io
);

  localparam logic [3:0] LAST = 4'(ITER - 1);

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  state_t             state_q, state_d;
  logic signed [31:0] x_q, y_q, z_q;
  logic [3:0]         iter_q;
  logic               neg_q, err_q;
  logic               in_ready_q, out_valid_q, range_err_q;
  logic signed [31:0] cos_q, sin_q;

  // Micro-rotation angles atan(2^-i) in degrees x 2^16.
  function automatic logic signed [31:0] rot_angle(input logic [3:0] i);
    case (i)
      4'd0:    return 32'sd2949120;
      4'd1:    return 32'sd1740970;
      4'd2:    return 32'sd919876;
      4'd3:    return 32'sd466944;
      4'd4:    return 32'sd234376;
      4'd5:    return 32'sd117303;
      4'd6:    return 32'sd58668;
      4'd7:    return 32'sd29334;
      4'd8:    return 32'sd14667;
      4'd9:    return 32'sd7333;
      4'd10:   return 32'sd3670;
      4'd11:   return 32'sd1835;
      4'd12:   return 32'sd918;
      4'd13:   return 32'sd459;
      4'd14:   return 32'sd229;
      default: return 32'sd118;
    endcase
  endfunction

  logic               accept;
  logic signed [31:0] x_sh, y_sh, rot;
  logic signed [31:0] x_nx, y_nx, z_nx;
  logic signed [31:0] z_in;
  logic               neg_in, err_in;

  // in_ready_q is only ever high while in IDLE, so accept implies IDLE.
  assign accept = io.in_valid && in_ready_q;

  // Quadrant fold: angles beyond +-90 deg are pulled back by 180 deg and the
  // result negated at the end, keeping z inside the CORDIC convergence range.
  always_comb begin
    z_in   = io.angle_in;
    neg_in = 1'b0;
    if (io.angle_in > DEG90) begin
      z_in   = io.angle_in - DEG180;
      neg_in = 1'b1;
    end else if (io.angle_in < -DEG90) begin
      z_in   = io.angle_in + DEG180;
      neg_in = 1'b1;
    end
    err_in = (io.angle_in > DEG180) || (io.angle_in < -DEG180);
  end

  // One micro-rotation; direction chosen by the sign of the residual angle.
  always_comb begin
    x_sh = x_q >>> iter_q;
    y_sh = y_q >>> iter_q;
    rot  = rot_angle(iter_q);
    if (!z_q[31]) begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - rot;
    end else begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
      z_nx = z_q + rot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROTATE;
      ROTATE:  if (iter_q == LAST) state_d = DONE;
      DONE:    if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      iter_q      <= '0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      range_err_q <= 1'b0;
      cos_q       <= '0;
      sin_q       <= '0;
    end else begin
      // Registered so it rises one cycle after reset release and one cycle
      // after the output handshake, never on the handshake edge itself.
      in_ready_q <= (state_d == IDLE);
      if (accept) begin
        x_q    <= KN;
        y_q    <= '0;
        z_q    <= z_in;
        iter_q <= '0;
        neg_q  <= neg_in;
        err_q  <= err_in;
      end else if (state_q == ROTATE) begin
        x_q    <= x_nx;
        y_q    <= y_nx;
        z_q    <= z_nx;
        iter_q <= iter_q + 4'd1;
        if (iter_q == LAST) begin
          cos_q       <= err_q ? 32'sd0 : (neg_q ? -x_nx : x_nx);
          sin_q       <= err_q ? 32'sd0 : (neg_q ? -y_nx : y_nx);
          range_err_q <= err_q;
          out_valid_q <= 1'b1;
        end
      end else if (state_q == DONE && io.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.cos_out   = cos_q;
  assign io.sin_out   = sin_q;
  assign io.range_err = range_err_q;
  assign io.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cordic_sincos.sv
// Testbench for cordic_sincos: scoreboard of expected cos/sin/err per accepted angle.
// Latency and throughput are measured against an edge counter.
// Backpressure exercised by holding out_ready low with stray in_valid pulses.
module tb_cordic_sincos;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  cordic_sincos_if bus ();

  cordic_sincos dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  typedef struct {
    logic signed [31:0] c;
    logic signed [31:0] s;
    logic               e;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Angle table with expected results (round(2^16*cos/sin), checked +-8 LSB).
  logic signed [31:0] t_ang [6] = '{32'sd0, 32'sd1966080, -32'sd1966080,
                                     32'sd8847360, 32'sd12000000, -32'sd5898240};
  logic signed [31:0] t_cos [6] = '{32'sd65536, 32'sd56756, 32'sd56756,
                                     -32'sd46341, 32'sd0, 32'sd0};
  logic signed [31:0] t_sin [6] = '{32'sd0, 32'sd32768, -32'sd32768,
                                     32'sd46341, 32'sd0, -32'sd65536};
  logic               t_err [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  string              t_nm  [6] = '{"zero", "p30", "m30", "p135", "range", "m90"};

  // Waits (bounded) for in_ready, presents one angle for one edge, pushes expectation.
  task automatic send(input logic signed [31:0] a, input logic signed [31:0] ec,
                      input logic signed [31:0] es, input logic ee, output int acc);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      tests++; fails++;
      $display("FAIL send_in_ready_timeout: in_ready=%0b required=1", bus.in_ready);
      acc = -1;
      return;
    end
    bus.in_valid = 1'b1;
    bus.angle_in = a;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    acc = cyc;
    sb.push_back('{c: ec, s: es, e: ee});
  endtask

  // Waits (bounded) for out_valid; returns the edge count it was seen at.
  task automatic wait_out(output int at);
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.out_valid) begin
      tests++; fails++;
      $display("FAIL out_valid_timeout: out_valid=%0b required=1", bus.out_valid);
      at = -1;
    end else begin
      at = cyc;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus.out_valid, bus.range_err, bus.busy, bus.in_ready} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: ov/err/busy/rdy=%b required=0000",
               {bus.out_valid, bus.range_err, bus.busy, bus.in_ready});
    end
    tests++;
    if (bus.cos_out !== 32'sd0 || bus.sin_out !== 32'sd0) begin
      fails++;
      $display("FAIL reset_data: cos=%0d sin=%0d required 0 0", bus.cos_out, bus.sin_out);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_rdy_at_release: in_ready=%0b required=0", bus.in_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_rdy_after_edge: in_ready=%0b required=1", bus.in_ready);
    end
  endtask

  task automatic test_angle_table();
    int   acc, at, dc, ds;
    exp_t e;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send(t_ang[k], t_cos[k], t_sin[k], t_err[k], acc);
      wait_out(at);
      if (at < 0 || acc < 0) continue;
      tests++;
      if (at - acc !== 16) begin
        fails++;
        $display("FAIL %s latency: got=%0d required=16", t_nm[k], at - acc);
      end
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL %s scoreboard_empty: size=0 required>=1", t_nm[k]);
        continue;
      end
      e  = sb.pop_front();
      dc = int'(bus.cos_out) - int'(e.c);
      ds = int'(bus.sin_out) - int'(e.s);
      tests++;
      if (dc > 8 || dc < -8) begin
        fails++;
        $display("FAIL %s cos: got=%0d required=%0d+-8", t_nm[k], bus.cos_out, e.c);
      end
      tests++;
      if (ds > 8 || ds < -8) begin
        fails++;
        $display("FAIL %s sin: got=%0d required=%0d+-8", t_nm[k], bus.sin_out, e.s);
      end
      tests++;
      if (bus.range_err !== e.e) begin
        fails++;
        $display("FAIL %s range_err: got=%0b required=%0b", t_nm[k], bus.range_err, e.e);
      end
      if (e.e) begin
        tests++;
        if (bus.cos_out !== 32'sd0 || bus.sin_out !== 32'sd0) begin
          fails++;
          $display("FAIL %s err_zeroed: cos=%0d sin=%0d required 0 0",
                   t_nm[k], bus.cos_out, bus.sin_out);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc, pulses;
    bus.out_ready = 1'b1;
    send(32'sd1966080, 32'sd56756, 32'sd32768, 1'b0, acc);
    repeat (7) @(posedge clk);
    #1;
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_busy_before: busy=%0b required=1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    sb.delete();
    tests++;
    if (bus.cos_out !== 32'sd0 || bus.sin_out !== 32'sd0 || bus.range_err !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_data: cos=%0d sin=%0d err=%0b required 0 0 0",
               bus.cos_out, bus.sin_out, bus.range_err);
    end
    tests++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_state: out_valid=%0b busy=%0b required 0 0", bus.out_valid, bus.busy);
    end
    #5 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) pulses++;
    end
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL rstmid_no_output: out_valid cycles=%0d required=0", pulses);
    end
    tests++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_idle: in_ready=%0b busy=%0b required 1 0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    int                 acc, at, dc, ds;
    exp_t               e;
    logic signed [31:0] c0, s0;
    bus.out_ready = 1'b0;
    send(32'sd8847360, -32'sd46341, 32'sd46341, 1'b0, acc);
    wait_out(at);
    if (at < 0 || sb.size() == 0) return;
    e  = sb.pop_front();
    dc = int'(bus.cos_out) - int'(e.c);
    ds = int'(bus.sin_out) - int'(e.s);
    tests++;
    if (dc > 8 || dc < -8 || ds > 8 || ds < -8) begin
      fails++;
      $display("FAIL bp_result: cos=%0d sin=%0d required %0d %0d +-8",
               bus.cos_out, bus.sin_out, e.c, e.s);
    end
    c0 = bus.cos_out;
    s0 = bus.sin_out;
    for (int k = 0; k < 20; k++) begin
      bus.in_valid = k[0];
      bus.angle_in = 32'sd1966080;
      @(posedge clk); #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold_flags cyc%0d: out_valid=%0b in_ready=%0b required 1 0",
                 k, bus.out_valid, bus.in_ready);
      end
      tests++;
      if (bus.cos_out !== c0 || bus.sin_out !== s0) begin
        fails++;
        $display("FAIL bp_hold_data cyc%0d: cos=%0d sin=%0d required %0d %0d",
                 k, bus.cos_out, bus.sin_out, c0, s0);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release_valid: out_valid=%0b required=0", bus.out_valid);
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_ready: in_ready=%0b required=1", bus.in_ready);
    end
    tests++;
    if (bus.cos_out !== c0 || bus.sin_out !== s0) begin
      fails++;
      $display("FAIL bp_retain: cos=%0d sin=%0d required %0d %0d", bus.cos_out, bus.sin_out, c0, s0);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_no_capture: busy=%0b out_valid=%0b required 0 0", bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int   acc, prev, at, dc, ds;
    exp_t e;
    bus.out_ready = 1'b1;
    prev = -1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 6; k++) begin
        send(t_ang[k], t_cos[k], t_sin[k], t_err[k], acc);
        if (prev >= 0 && acc >= 0) begin
          tests++;
          if (acc - prev !== 18) begin
            fails++;
            $display("FAIL b2b_period %s: got=%0d required=18", t_nm[k], acc - prev);
          end
        end
        prev = acc;
        wait_out(at);
        if (at < 0 || sb.size() == 0) continue;
        e  = sb.pop_front();
        dc = int'(bus.cos_out) - int'(e.c);
        ds = int'(bus.sin_out) - int'(e.s);
        tests++;
        if (dc > 8 || dc < -8 || ds > 8 || ds < -8 || bus.range_err !== e.e) begin
          fails++;
          $display("FAIL b2b_result %s: cos=%0d sin=%0d err=%0b required %0d %0d %0b",
                   t_nm[k], bus.cos_out, bus.sin_out, bus.range_err, e.c, e.s, e.e);
        end
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.angle_in  = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_angle_table();
    test_reset_mid();
    test_backpressure();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
